// File: rtl/booth_radix4_mult_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_radix4_mult_param
//   Sequential radix-4 Booth multiplier, WIDTH-generic, signed/unsigned mode,
//   one recoded digit retired per clock, go/over/busy handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
module booth_radix4_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mplier,
  input  logic [WIDTH-1:0]     mcand,
  output logic [2*WIDTH-1:0]   product,
  output logic                 over,
  output logic                 busy,
  output logic [1:0]           state
);

  localparam int W2 = WIDTH + 2;
  localparam int N  = W2 / 2;
  localparam int HW = W2 + 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      next_state;
  logic [W2-1:0]   cand;
  logic [HW-1:0]   hi;
  logic [W2-1:0]   lo;
  logic            prev;
  logic [CW-1:0]   step;

  logic [W2-1:0]   mplier_ext;
  logic [W2-1:0]   mcand_ext;
  logic [HW-1:0]   cand_w;
  logic [HW-1:0]   addend;
  logic [HW-1:0]   sum;
  logic [HW-1:0]   new_hi;
  logic [W2-1:0]   new_lo;
  logic [2*W2-1:0] full;
  logic            unused_bits;

  // Both modes share one signed recoder thanks to the 2-bit extension.
  assign mplier_ext = signed_mode ? {{2{mplier[WIDTH-1]}}, mplier} : {2'b00, mplier};
  assign mcand_ext  = signed_mode ? {{2{mcand[WIDTH-1]}}, mcand}   : {2'b00, mcand};
  assign cand_w     = {{2{cand[W2-1]}}, cand};

  always_comb begin
    addend = '0;
    case ({lo[1:0], prev})
      3'b001, 3'b010: addend = cand_w;
      3'b011:         addend = cand_w << 1;
      3'b100:         addend = -(cand_w << 1);
      3'b101, 3'b110: addend = -cand_w;
      default:        addend = '0;
    endcase
  end

  assign sum    = hi + addend;
  assign new_hi = {{2{sum[HW-1]}}, sum[HW-1:2]};
  assign new_lo = {sum[1:0], lo[W2-1:2]};
  assign full   = {new_hi[W2-1:0], new_lo};

  assign unused_bits = ^{new_hi[HW-1:W2], full[2*W2-1:2*WIDTH]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = go ? CALC : IDLE;
      CALC:    next_state = (step == LAST) ? DONE : CALC;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    over = 1'b0;
    busy = 1'b0;
    case (state)
      CALC: busy = 1'b1;
      DONE: begin
        over = 1'b1;
        busy = 1'b1;
      end
      default: begin
        over = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand    <= '0;
      hi      <= '0;
      lo      <= '0;
      prev    <= 1'b0;
      step    <= '0;
      product <= '0;
    end else begin
      if (state == IDLE && go) begin
        cand <= mcand_ext;
        lo   <= mplier_ext;
        hi   <= '0;
        prev <= 1'b0;
        step <= '0;
      end else if (state == CALC) begin
        hi   <= new_hi;
        lo   <= new_lo;
        prev <= lo[1];
        step <= step + 1'b1;
        // The last digit's result goes straight to the output register.
        if (step == LAST) begin
          product <= full[2*WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_mult_param.sv
`default_nettype none
// Scoreboard bench for booth_radix4_mult_param at WIDTH=8 and WIDTH=16.
module tb_booth_radix4_mult_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        go8, sm8, go16, sm16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [15:0] p8;
  logic [31:0] p16;
  logic        ov8, bz8, ov16, bz16;
  logic [1:0]  st8, st16;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp8_q[$];
  logic [31:0] exp16_q[$];

  always #5 clk = ~clk;

  booth_radix4_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .signed_mode(sm8), .mplier(a8), .mcand(b8),
    .product(p8), .over(ov8), .busy(bz8), .state(st8)
  );

  booth_radix4_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16), .signed_mode(sm16), .mplier(a16), .mcand(b16),
    .product(p16), .over(ov16), .busy(bz16), .state(st16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every over pulse pops one expected product.
  always @(negedge clk) begin
    if (rst === 1'b1 && ov8 === 1'b1) begin
      if (exp8_q.size() == 0) chk("unexpected_over8", 32'(p8), 32'hDEAD_BEEF);
      else chk("product8", 32'(p8), 32'(exp8_q.pop_front()));
    end
    if (rst === 1'b1 && ov16 === 1'b1) begin
      if (exp16_q.size() == 0) chk("unexpected_over16", p16, 32'hDEAD_BEEF);
      else chk("product16", p16, exp16_q.pop_front());
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] e, input bit tchk);
    int lat = -1;
    int bcnt = 0;
    exp8_q.push_back(e);
    sm8 = sm; a8 = a; b8 = b; go8 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      go8 = 1'b0;
      if (bz8) bcnt++;
      if (ov8) begin lat = k - 1; break; end
    end
    if (lat < 0) chk("timeout8", 32'(lat), 32'd5);
    else if (tchk) begin
      chk("latency8", 32'(lat), 32'd5);
      chk("busy_cycles8", 32'(bcnt), 32'd6);
    end
    @(negedge clk);
    if (tchk) begin
      chk("over_width8", 32'(ov8), 32'd0);
      chk("back_idle8", 32'(st8), 32'd0);
    end
  endtask

  task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] e, input bit tchk);
    int lat = -1;
    int bcnt = 0;
    exp16_q.push_back(e);
    sm16 = sm; a16 = a; b16 = b; go16 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      go16 = 1'b0;
      if (bz16) bcnt++;
      if (ov16) begin lat = k - 1; break; end
    end
    if (lat < 0) chk("timeout16", 32'(lat), 32'd9);
    else if (tchk) begin
      chk("latency16", 32'(lat), 32'd9);
      chk("busy_cycles16", 32'(bcnt), 32'd10);
    end
    @(negedge clk);
    if (tchk) chk("back_idle16", 32'(st16), 32'd0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb, e8;
    logic [31:0] e16;
    longint      sa, sb, lp;
    int          last, n, k;

    rst = 1'b0;
    go8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    go16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_state8", 32'(st8), 32'd0);
    chk("rst_busy8", 32'(bz8), 32'd0);
    chk("rst_over8", 32'(ov8), 32'd0);
    chk("rst_product8", 32'(p8), 32'd0);
    chk("rst_product16", p16, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8
    run8(1'b0, 8'd120, 8'd3,  16'h0168, 1'b1);
    chk("held_product8", 32'(p8), 32'h0168);
    run8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
    run8(1'b1, 8'hFF, 8'h7F, 16'hFF81, 1'b1);
    run8(1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1);
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    run8(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b1);
    run8(1'b1, 8'h03, 8'hFB, 16'hFFF1, 1'b1);
    run8(1'b0, 8'h00, 8'hC8, 16'h0000, 1'b1);

    // go and operand changes during CALC are ignored
    exp8_q.push_back(16'h0168);
    sm8 = 1'b0; a8 = 8'd120; b8 = 8'd3; go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0; a8 = 8'd55; b8 = 8'd77; sm8 = 1'b1;
    @(negedge clk);
    chk("calc_product_stable8", 32'(p8), 32'h0000);
    go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    repeat (15) @(negedge clk);
    chk("pending_after_ignore8", 32'(exp8_q.size()), 32'd0);

    // go held high: a result every N+2 clocks, operands refreshed between ops
    sm8 = 1'b0; a8 = 8'd13; b8 = 8'd11; exp8_q.push_back(16'd143);
    go8 = 1'b1; last = -1; n = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ov8) begin
        n++;
        if (last >= 0) chk("hold_period8", 32'(k - last), 32'd7);
        last = k;
        if (n == 3) begin go8 = 1'b0; break; end
        a8 = 8'(a8 + 8'd20); b8 = 8'(b8 + 8'd9);
        exp8_q.push_back(16'(a8) * 16'(b8));
      end
    end
    chk("hold_count8", 32'(n), 32'd3);
    repeat (12) @(negedge clk);

    // Async reset mid-CALC
    exp8_q.push_back(16'd10000);
    sm8 = 1'b0; a8 = 8'd100; b8 = 8'd100; go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_state8", 32'(st8), 32'd0);
    chk("midrst_busy8", 32'(bz8), 32'd0);
    chk("midrst_over8", 32'(ov8), 32'd0);
    chk("midrst_product8", 32'(p8), 32'd0);
    exp8_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run8(1'b0, 8'd7, 8'd9, 16'd63, 1'b1);

    // Directed WIDTH=16
    run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    run16(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
    run16(1'b1, 16'hFFFF, 16'h7FFF, 32'hFFFF8001, 1'b1);

    // Random sweep against the '*' operator
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom); rb = 8'($urandom);
        wa = 16'($urandom); wb = 16'($urandom);
        if (m == 0) begin
          e8  = 16'(ra) * 16'(rb);
          e16 = 32'(wa) * 32'(wb);
        end else begin
          sa = longint'($signed(ra)); sb = longint'($signed(rb)); lp = sa * sb;
          e8 = lp[15:0];
          sa = longint'($signed(wa)); sb = longint'($signed(wb)); lp = sa * sb;
          e16 = lp[31:0];
        end
        run8(m[0], ra, rb, e8, 1'b0);
        run16(m[0], wa, wb, e16, 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    chk("pending8", 32'(exp8_q.size()), 32'd0);
    chk("pending16", 32'(exp16_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
